// File: rtl/ifmap_write_feeder_if.sv
// ifmap_write_feeder_if: source-memory read port and IFMap FIFO write port
// seen from the feeder (master) and from the memory/FIFO side (slave).
interface ifmap_write_feeder_if #(
   parameter int DATA_WIDTH = 16,
   parameter int ADDR_WIDTH = 8
);
   logic                  mem_ren;
   logic [ADDR_WIDTH-1:0] mem_addr;
   logic [DATA_WIDTH-1:0] mem_rdata;
   logic                  fifo_full;
   logic                  wen;
   logic [DATA_WIDTH+1:0] dout;
   modport master (output mem_ren, mem_addr, wen, dout, input mem_rdata, fifo_full);
   modport slave  (input mem_ren, mem_addr, wen, dout, output mem_rdata, fifo_full);
endinterface

// File: rtl/ifmap_write_feeder.sv
// ifmap_write_feeder: streams rows of source memory into the IFMap FIFO, tagging row/map ends.
// Optional zero-pad rows compiled in with IFMAP_FEEDER_ZERO_PAD_EN.
module ifmap_write_feeder #(
   parameter int DATA_WIDTH = 16,
   parameter int ADDR_WIDTH = 8,
   parameter int LEN_WIDTH  = 8
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  start,
   input  logic [ADDR_WIDTH-1:0] base_addr,
   input  logic [LEN_WIDTH-1:0]  row_len,
   input  logic [LEN_WIDTH-1:0]  num_rows,
   input  logic                  pad_en,
   ifmap_write_feeder_if.master  bus,
   output logic                  busy,
   output logic                  done
);
   localparam logic [1:0] IDLE = 2'd0;
   localparam logic [1:0] READ = 2'd1;
   localparam logic [1:0] PUSH = 2'd2;
   localparam logic [1:0] DONE = 2'd3;
   logic [1:0]            state;
   logic [ADDR_WIDTH-1:0] addr;
   logic [LEN_WIDTH:0]    col, col_nxt, row_words;
   logic [LEN_WIDTH-1:0]  row, len_q, rows_q;
   logic [DATA_WIDTH-1:0] hold, payload;
   logic fresh, pad_q, pad_req, last_col, last_row, cur_pad, nxt_pad, write;
`ifdef IFMAP_FEEDER_ZERO_PAD_EN
   assign pad_req = pad_en;
   always_ff @(posedge clk)
      if (rst) pad_q <= 1'b0;
      else if (state == IDLE && start) pad_q <= pad_en;
`else
   logic unused_pad_en;
   assign unused_pad_en = pad_en;
   assign pad_req = 1'b0;
   assign pad_q = 1'b0;
`endif
   // a padded row carries one zero word at each end
   assign row_words = (LEN_WIDTH+1)'(len_q) + (pad_q ? (LEN_WIDTH+1)'(2) : '0);
   assign last_col = col == row_words - 1'b1;
   assign last_row = row == rows_q - 1'b1;
   assign col_nxt = last_col ? '0 : col + 1'b1;
   assign cur_pad = pad_q && (col == '0 || last_col);
   assign nxt_pad = pad_q && (col_nxt == '0 || col_nxt == row_words - 1'b1);
   assign write = state == PUSH && !bus.fifo_full;
   // read data arrives during the first PUSH cycle; hold keeps it for stalls
   assign payload = cur_pad ? '0 : (fresh ? bus.mem_rdata : hold);
   assign bus.mem_ren = state == READ;
   assign bus.mem_addr = addr;
   assign bus.wen = write;
   assign bus.dout = state == PUSH ? {last_col && last_row, last_col, payload} : '0;
   assign busy = state != IDLE;
   assign done = state == DONE;
   always_ff @(posedge clk) begin
      if (rst) begin
         state <= IDLE;
         addr <= '0;
         col <= '0;
         row <= '0;
         len_q <= '0;
         rows_q <= '0;
         hold <= '0;
         fresh <= 1'b0;
      end else begin
         fresh <= state == READ;
         if (fresh) hold <= bus.mem_rdata;
         if (state == IDLE && start) begin
            addr <= base_addr;
            len_q <= row_len;
            rows_q <= num_rows;
            col <= '0;
            row <= '0;
            state <= (row_len == '0 || num_rows == '0) ? DONE : (pad_req ? PUSH : READ);
         end else if (state == READ) begin
            addr <= addr + 1'b1;
            state <= PUSH;
         end else if (write) begin
            col <= col_nxt;
            if (last_col) row <= row + 1'b1;
            state <= (last_col && last_row) ? DONE : (nxt_pad ? PUSH : READ);
         end else if (state == DONE) begin
            state <= IDLE;
         end
      end
   end
endmodule

// File: tb/tb_ifmap_write_feeder.sv
// tb_ifmap_write_feeder: directed and random jobs checked against a queue-based model of the word stream.
module tb_ifmap_write_feeder;
   localparam int DW = 16;
   localparam int AW = 8;
   localparam int LW = 8;
`ifdef IFMAP_FEEDER_ZERO_PAD_EN
   localparam bit PAD_ON = 1'b1;
`else
   localparam bit PAD_ON = 1'b0;
`endif
   logic clk = 1'b0, rst = 1'b1, start = 1'b0, pad_en = 1'b0;
   logic [AW-1:0] base_addr = '0;
   logic [LW-1:0] row_len = '0, num_rows = '0;
   logic busy, done;
   logic [DW-1:0] mem [256];
   logic [DW-1:0] rdata_q = '0;
   logic [DW+1:0] exp_w [$];
   logic [AW-1:0] exp_a [$];
   int checks = 0, failures = 0;
   ifmap_write_feeder_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bus ();
   ifmap_write_feeder #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .LEN_WIDTH(LW)) dut (
      .clk(clk), .rst(rst), .start(start), .base_addr(base_addr), .row_len(row_len),
      .num_rows(num_rows), .pad_en(pad_en), .bus(bus), .busy(busy), .done(done));
   always #5 clk = ~clk;
   always @(posedge clk) if (bus.mem_ren) rdata_q <= mem[bus.mem_addr];
   assign bus.mem_rdata = rdata_q;
   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask
   // mode: 0 no backpressure, 1 random fifo_full, 2 fifo_full held for cycles 4..8
   task automatic run_job(input logic [AW-1:0] base, input logic [LW-1:0] len, input logic [LW-1:0] rows,
                          input logic pad, input int mode, input int rst_at);
      logic [DW+1:0] rowq [$];
      logic [DW+1:0] held;
      logic [AW-1:0] a;
      bit ep;
      int npay, npad, first_busy, done_cyc, nren, nwen, n;
      ep = pad && PAD_ON;
      npay = 0; npad = 0; first_busy = -1; done_cyc = -1; nren = 0; nwen = 0;
      held = '0;
      a = base;
      exp_w.delete();
      exp_a.delete();
      if (len != 0 && rows != 0)
         for (int r = 0; r < int'(rows); r++) begin
            rowq.delete();
            if (ep) begin rowq.push_back('0); npad++; end
            for (int c = 0; c < int'(len); c++) begin
               rowq.push_back({2'b00, mem[a]});
               exp_a.push_back(a);
               a = a + 1'b1;
               npay++;
            end
            if (ep) begin rowq.push_back('0); npad++; end
            n = rowq.size();
            rowq[n-1][DW] = 1'b1;
            if (r == int'(rows) - 1) rowq[n-1][DW+1] = 1'b1;
            foreach (rowq[i]) exp_w.push_back(rowq[i]);
         end
      @(posedge clk); #1;
      start = 1'b1; base_addr = base; row_len = len; num_rows = rows; pad_en = pad;
      bus.fifo_full = 1'b0;
      for (int cyc = 1; cyc <= 400 && done_cyc < 0; cyc++) begin
         @(posedge clk); #1;
         start = cyc == 2 && len != 0 && rows != 0;
         if (start) begin
            base_addr = AW'($urandom); row_len = LW'($urandom); num_rows = LW'($urandom); pad_en = ~pad;
         end
         rst = cyc == rst_at;
         bus.fifo_full = mode == 1 ? ($urandom_range(0, 2) == 0) : mode == 2 ? (cyc >= 4 && cyc <= 8) : 1'b0;
         @(negedge clk);
         if (rst_at > 0 && cyc == rst_at + 1) begin
            chk("rst_mem_ren", bus.mem_ren, 0);
            chk("rst_wen", bus.wen, 0);
            chk("rst_done", done, 0);
            chk("rst_busy", busy, 0);
            chk("rst_dout", bus.dout, 0);
            bus.fifo_full = 1'b0;
            return;
         end
         if (busy && first_busy < 0) first_busy = cyc;
         if (cyc == 1) chk("busy_rise", busy, 1);
         if (bus.mem_ren) begin
            nren++;
            if (exp_a.size() == 0) chk("extra_ren", 1, 0);
            else chk("addr", bus.mem_addr, exp_a.pop_front());
         end
         if (bus.wen) begin
            nwen++;
            if (nwen == 1 && mode != 1) chk("first_wen_lat", cyc, ep ? 1 : 2);
            if (exp_w.size() == 0) chk("extra_wen", 1, 0);
            else chk("wdata", bus.dout, exp_w.pop_front());
         end
         if (mode == 2 && cyc >= 4 && cyc <= 8) begin
            if (cyc == 4) held = bus.dout;
            else chk("stall_dout", bus.dout, held);
            chk("stall_wen", bus.wen, 0);
         end
         if (done) done_cyc = cyc;
      end
      if (done_cyc < 0) chk("timeout", 0, 1);
      else if (mode != 1) chk("done_lat", done_cyc - first_busy, 2 * npay + npad + (mode == 2 ? 5 : 0));
      start = 1'b0;
      bus.fifo_full = 1'b0;
      @(posedge clk); #1;
      @(negedge clk);
      chk("done_pulse", done, 0);
      chk("idle_busy", busy, 0);
      chk("ren_count", nren, npay);
      chk("wen_count", nwen, npay + npad);
      chk("words_left", exp_w.size(), 0);
   endtask
   initial begin
      bus.fifo_full = 1'b0;
      for (int i = 0; i < 256; i++) mem[i] = DW'($urandom);
      repeat (3) @(posedge clk);
      @(negedge clk);
      chk("reset_busy", busy, 0);
      chk("reset_done", done, 0);
      chk("reset_wen", bus.wen, 0);
      chk("reset_ren", bus.mem_ren, 0);
      chk("reset_dout", bus.dout, 0);
      rst = 1'b0;
      run_job(8'h10, 3, 2, 1'b0, 0, 0);
      run_job(8'h10, 3, 2, 1'b0, 2, 0);
      run_job(8'hFE, 4, 1, 1'b0, 0, 0);
      run_job(8'h20, 0, 5, 1'b0, 0, 0);
      run_job(8'h10, 3, 2, 1'b0, 0, 8);
      run_job(8'h10, 3, 2, 1'b0, 0, 0);
      run_job(8'h40, 2, 1, 1'b1, 0, 0);
      for (int j = 0; j < 12; j++)
         run_job(AW'($urandom), LW'($urandom_range(0, 5)), LW'($urandom_range(0, 4)),
                 1'($urandom_range(0, 1)), $urandom_range(0, 1), 0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule

// File: doc/ifmap_write_feeder.md
IFMAP_WRITE_FEEDER -- requirements
Module: ifmap_write_feeder

Interface
REQ-001 Parameter DATA_WIDTH, default 16, is the payload width; the FIFO word is DATA_WIDTH+2 bits (18).
REQ-002 Parameter ADDR_WIDTH, default 8, is the source-memory address width.
REQ-003 Parameter LEN_WIDTH, default 8, is the width of the row-length and row-count operands.
REQ-004 clk  in  1  single clock; all state updates on the rising edge.
REQ-005 rst  in  1  reset, synchronous and active-high.
REQ-006 start  in  1  one-cycle request; samples base_addr, row_len, num_rows, pad_en.
REQ-007 base_addr  in  ADDR_WIDTH  first source address.
REQ-008 row_len  in  LEN_WIDTH  payload words per row.
REQ-009 num_rows  in  LEN_WIDTH  rows per map.
REQ-010 pad_en  in  1  request zero padding (effective only per REQ-033).
REQ-011 mem_ren  out  1  source read strobe.
REQ-012 mem_addr  out  ADDR_WIDTH  source read address.
REQ-013 mem_rdata  in  DATA_WIDTH  source data, valid exactly one cycle after mem_ren.
REQ-014 fifo_full  in  1  IFMap FIFO cannot accept a word this cycle.
REQ-015 wen  out  1  FIFO write strobe.
REQ-016 dout  out  DATA_WIDTH+2  {end_of_map, end_of_row, payload}.
REQ-017 busy  out  1  high from the cycle after an accepted start until DONE is left.
REQ-018 done  out  1  one-cycle pulse after the last word is written.

Function
REQ-019 FSM states IDLE, READ, PUSH, DONE; reset state IDLE.
REQ-020 IDLE: on start, latch operands; row_len==0 or num_rows==0 -> DONE (no writes); else -> READ.
REQ-021 READ: mem_ren=1, mem_addr=current address; next cycle -> PUSH; hold register captures mem_rdata on PUSH entry.
REQ-022 PUSH: wen = !fifo_full, combinational; dout driven from hold register; stay in PUSH with dout stable while fifo_full=1.
REQ-023 On a write, word/row counters advance; more words remain -> READ, else -> DONE.
REQ-024 Throughput with no backpressure: one word per 2 cycles; first wen 2 cycles after start.
REQ-025 dout[DATA_WIDTH] (end_of_row) = 1 on the last word of each row; dout[DATA_WIDTH+1] (end_of_map) = 1 only on the last word of the last row.
REQ-026 Address increments by 1 per payload read, modulo 2^ADDR_WIDTH (wrap from all-ones to 0 is legal); rows are contiguous.
REQ-027 DONE: done=1 for exactly one cycle, then -> IDLE.
REQ-028 start while busy is ignored; operands are not re-sampled.
REQ-029 mem_ren, wen, done are 0 in every state/cycle not listed above.

Reset
REQ-030 rst=1 at any clock edge, including mid-row or mid-stall: state IDLE, counters/address/hold register 0, mem_ren=0, wen=0, done=0, busy=0, dout=0 on the following cycle.
REQ-031 rst has priority over start in the same cycle.

Configuration
REQ-032 Macro IFMAP_FEEDER_ZERO_PAD_EN compiles in row padding.
REQ-033 Defined and pad_en=1 at start: each row is emitted as one zero word, row_len payload words, one zero word (row_len+2 writes/row); pad words issue no mem_ren; end_of_row/end_of_map move to the trailing pad word.
REQ-034 Undefined: pad_en is ignored and no padding logic exists; behaviour identical to pad_en=0.

Verification
REQ-035 base=0x10, row_len=3, num_rows=2, no backpressure -> reads 0x10..0x15, 6 writes, end_of_row on writes 3 and 6, end_of_map only on write 6, done 12 cycles after start.
REQ-036 Same job with fifo_full=1 for 5 cycles on write 2 -> dout held constant, wen=0 during stall, no extra mem_ren, data order unchanged, done delayed by 5 cycles.
REQ-037 base=0xFE, row_len=4, num_rows=1 -> addresses 0xFE, 0xFF, 0x00, 0x01.
REQ-038 row_len=0 (num_rows=5) -> no mem_ren, no wen, done pulses once.
REQ-039 rst asserted on write 4 of REQ-035 job -> next cycle all outputs 0; subsequent start runs full job correctly.
REQ-040 With IFMAP_FEEDER_ZERO_PAD_EN, pad_en=1, row_len=2, num_rows=1 -> dout payloads 0, D0, D1, 0; only 2 mem_ren; end_of_row and end_of_map on write 4.
